// File: rtl/ps2_key_event_decoder_if.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_key_event_decoder_if
//  Description : Bus between the PS/2 byte source / key-event consumer and
//                ps2_key_event_decoder. The decoder takes the slave side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface ps2_key_event_decoder_if #(
  parameter int CNT_W = 2
);
  logic             scan_valid;
  logic [7:0]       scan_data;
  logic             rd_key;
  logic             clr_ovf;
  logic [9:0]       key_event;
  logic             kb_buf_empty;
  logic             kb_buf_full;
  logic [CNT_W-1:0] key_count;
  logic             cmd_tick;
  logic             overflow;

  // Byte source / event consumer side
  modport master (
    output scan_valid, scan_data, rd_key, clr_ovf,
    input  key_event, kb_buf_empty, kb_buf_full, key_count, cmd_tick, overflow
  );

  // Decoder side
  modport slave (
    input  scan_valid, scan_data, rd_key, clr_ovf,
    output key_event, kb_buf_empty, kb_buf_full, key_count, cmd_tick, overflow
  );
endinterface
`default_nettype wire

// File: rtl/ps2_key_event_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_key_event_decoder
//  Description : PS/2 scan-code decoder. Tracks make / break (F0) / extended
//                (E0) prefixes, queues tagged events {ext, brk, code} in a
//                first-word-fall-through FIFO of 2**W entries, counts accepted
//                break events modulo CNT_MOD, and turns the non-extended
//                release of CMD_CODE into a one-cycle cmd_tick.
//                Build option: define KB_MAKE_EVENTS_EN to also queue make
//                events; by default only releases are queued.
//  Revision    : 1.0 - initial release
// ============================================================================
module ps2_key_event_decoder #(
  parameter int         W        = 2,
  parameter logic [7:0] CMD_CODE = 8'h31,
  parameter int         CNT_W    = 2,
  parameter int         CNT_MOD  = 2
) (
  input  wire logic clk,
  input  wire logic reset,
  ps2_key_event_decoder_if.slave bus
);

  localparam int               c_depth      = 2 ** W;
  localparam logic [W:0]       c_full_level = (W + 1)'(c_depth);
  localparam logic [CNT_W-1:0] c_cnt_last   = CNT_W'(CNT_MOD - 1);
  localparam logic [7:0]       c_code_e0    = 8'hE0;
  localparam logic [7:0]       c_code_f0    = 8'hF0;

`ifdef KB_MAKE_EVENTS_EN
  localparam bit c_make_en = 1'b1;
`else
  localparam bit c_make_en = 1'b0;
`endif

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXT     = 2'd1,
    ST_BRK     = 2'd2,
    ST_EXT_BRK = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_next;

  logic             w_evt_valid;
  logic             w_evt_ext;
  logic             w_evt_brk;
  logic [9:0]       w_evt;
  logic             w_is_cmd;
  logic             w_push_req;
  logic             w_can_push;
  logic             w_push;
  logic             w_pop;
  logic             w_empty;
  logic             w_full;
  logic             w_is_e0;
  logic             w_is_f0;

  logic [9:0]       r_mem [c_depth];
  logic [W-1:0]     r_wr_ptr;
  logic [W-1:0]     r_rd_ptr;
  logic [W:0]       r_level;
  logic [CNT_W-1:0] r_key_count;
  logic             r_cmd_tick;
  logic             r_overflow;

  assign w_is_e0 = (bus.scan_data == c_code_e0);
  assign w_is_f0 = (bus.scan_data == c_code_f0);

  // Prefix-tracking state register; a reset drops any partial prefix.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state and event decode; only a valid byte moves the FSM.
  always_comb begin
    w_state_next = r_state;
    w_evt_valid  = 1'b0;
    w_evt_ext    = 1'b0;
    w_evt_brk    = 1'b0;
    if (bus.scan_valid) begin
      case (r_state)
        ST_IDLE: begin
          if (w_is_e0) begin
            w_state_next = ST_EXT;
          end else if (w_is_f0) begin
            w_state_next = ST_BRK;
          end else begin
            w_evt_valid = 1'b1;
          end
        end
        ST_EXT: begin
          if (w_is_f0) begin
            w_state_next = ST_EXT_BRK;
          end else if (w_is_e0) begin
            w_state_next = ST_EXT;
          end else begin
            w_evt_valid  = 1'b1;
            w_evt_ext    = 1'b1;
            w_state_next = ST_IDLE;
          end
        end
        ST_BRK: begin
          if (w_is_f0) begin
            w_state_next = ST_BRK;
          end else if (w_is_e0) begin
            w_state_next = ST_EXT_BRK;
          end else begin
            w_evt_valid  = 1'b1;
            w_evt_brk    = 1'b1;
            w_state_next = ST_IDLE;
          end
        end
        ST_EXT_BRK: begin
          if (w_is_e0 || w_is_f0) begin
            w_state_next = ST_EXT_BRK;
          end else begin
            w_evt_valid  = 1'b1;
            w_evt_ext    = 1'b1;
            w_evt_brk    = 1'b1;
            w_state_next = ST_IDLE;
          end
        end
        default: begin
          w_state_next = ST_IDLE;
        end
      endcase
    end
  end

  assign w_evt = {w_evt_ext, w_evt_brk, bus.scan_data};

  // Plain release of the command key becomes a tick instead of an entry.
  assign w_is_cmd = w_evt_valid && w_evt_brk && !w_evt_ext &&
                    (bus.scan_data == CMD_CODE);

  // Make events are queued only in the make-reporting build.
  assign w_push_req = w_evt_valid && !w_is_cmd && (w_evt_brk || c_make_en);

  assign w_empty = (r_level == '0);
  assign w_full  = (r_level == c_full_level);

  // A full FIFO can still take the event when the head is popped this cycle.
  assign w_can_push = !w_full || bus.rd_key;
  assign w_push     = w_push_req && w_can_push;
  assign w_pop      = bus.rd_key && !w_empty;

  // Storage array; contents are only observed through valid entries.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_evt;
    end
  end

  // Pointers wrap naturally at 2**W; level tracks occupancy 0..2**W.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + (W + 1)'(1);
        2'b01:   r_level <= r_level - (W + 1)'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // Modulo counter of break events that actually made it into the FIFO.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_key_count <= '0;
    end else if (w_push && w_evt_brk) begin
      if (r_key_count == c_cnt_last) begin
        r_key_count <= '0;
      end else begin
        r_key_count <= r_key_count + CNT_W'(1);
      end
    end
  end

  // Command tick lasts exactly the cycle after the release byte.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cmd_tick <= 1'b0;
    end else begin
      r_cmd_tick <= w_is_cmd;
    end
  end

  // Sticky overflow; a drop in the same cycle as a clear wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_overflow <= 1'b0;
    end else if (w_push_req && !w_can_push) begin
      r_overflow <= 1'b1;
    end else if (bus.clr_ovf) begin
      r_overflow <= 1'b0;
    end
  end

  // Head is forced to zero when nothing valid is queued.
  assign bus.key_event    = w_empty ? 10'd0 : r_mem[r_rd_ptr];
  assign bus.kb_buf_empty = w_empty;
  assign bus.kb_buf_full  = w_full;
  assign bus.key_count    = r_key_count;
  assign bus.cmd_tick     = r_cmd_tick;
  assign bus.overflow     = r_overflow;

endmodule
`default_nettype wire
